// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC instruction fetch stage.
// Optional feature macro: FETCH_HALT_EN adds the HALT state.
package fetch_pkg;

    localparam int                 INSTR_W   = 16;
    localparam logic [4:0]         OPC_HALT  = 5'b00000;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;

    typedef enum logic [2:0] {
        BOOT,
        REQ,
        DROP,
`ifdef FETCH_HALT_EN
        VALID,
        HALT
`else
        VALID
`endif
    } state_t;

    // Sequential PC step; wraps modulo 2^16.
    function automatic logic [INSTR_W-1:0] pc_step(input logic [INSTR_W-1:0] addr);
        return addr + INSTR_W'(2);
    endfunction

endpackage

// File: rtl/fetch_ibuf.sv
// Single-entry buffer holding the fetched instruction and its incremented PC.
// load wins over flush; with neither asserted the entry holds.
module fetch_ibuf
    import fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC_INC = 16'h0002
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               flush,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [INSTR_W-1:0] load_pc_inc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] pc_inc
);

    // Capture on load, drop the valid flag on flush, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            instr  <= NOP_INSTR;
            pc_inc <= RESET_PC_INC;
        end else if (load) begin
            valid  <= 1'b1;
            instr  <= load_instr;
            pc_inc <= load_pc_inc;
        end else if (flush) begin
            valid  <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// WISC fetch stage: owns the PC, requests instruction memory over req/ack
// and presents one buffered instruction to decode under valid/ready.
// Optional feature macro: FETCH_HALT_EN (stop fetching after a consumed HALT).
// Handshakes: imem_req stays high with a stable imem_addr until imem_ack;
// if_valid holds if_instr/if_pc_inc stable until id_ready (or a redirect).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [INSTR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [INSTR_W-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect,
    input  logic [INSTR_W-1:0] redirect_pc,
    input  logic               id_ready,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [INSTR_W-1:0] if_pc_inc,
    output logic               halted
);

    state_t             state, state_next;
    logic [INSTR_W-1:0] pc, pc_next;
    logic [INSTR_W-1:0] req_addr, req_addr_next;
    logic               buf_load, buf_flush;
    logic [INSTR_W-1:0] req_addr_inc;

    assign req_addr_inc = pc_step(req_addr);

    // State, PC and outstanding-request address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            req_addr <= req_addr_next;
        end
    end

    // Next-state, PC update and buffer control.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        req_addr_next = req_addr;
        buf_load      = 1'b0;
        buf_flush     = 1'b0;
        case (state)
            BOOT: begin
                state_next    = REQ;
                req_addr_next = pc;
            end
            REQ: begin
                if (imem_ack && !redirect) begin
                    buf_load   = 1'b1;
                    pc_next    = req_addr_inc;
                    state_next = VALID;
                end else if (imem_ack) begin
                    // Data belongs to the wrong path; refetch at the target now.
                    pc_next       = redirect_pc;
                    req_addr_next = redirect_pc;
                end else if (redirect) begin
                    // Request must complete at the old address before retargeting.
                    pc_next    = redirect_pc;
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    pc_next       = redirect ? redirect_pc : pc;
                    req_addr_next = redirect ? redirect_pc : pc;
                    state_next    = REQ;
                end else if (redirect) begin
                    pc_next = redirect_pc;
                end
            end
            VALID: begin
                if (redirect) begin
                    buf_flush     = 1'b1;
                    pc_next       = redirect_pc;
                    req_addr_next = redirect_pc;
                    state_next    = REQ;
                end else if (id_ready) begin
                    buf_flush     = 1'b1;
                    req_addr_next = pc;
`ifdef FETCH_HALT_EN
                    state_next    = (if_instr[15:11] == OPC_HALT) ? HALT : REQ;
`else
                    state_next    = REQ;
`endif
                end
            end
`ifdef FETCH_HALT_EN
            HALT: begin
                state_next = HALT;
            end
`endif
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign imem_req  = (state == REQ) || (state == DROP);
    assign imem_addr = req_addr;
`ifdef FETCH_HALT_EN
    assign halted    = (state == HALT);
`else
    assign halted    = 1'b0;
`endif

    fetch_ibuf #(
        .RESET_PC_INC (pc_step(RESET_PC))
    ) u_ibuf (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (buf_load),
        .flush       (buf_flush),
        .load_instr  (imem_rdata),
        .load_pc_inc (req_addr_inc),
        .valid       (if_valid),
        .instr       (if_instr),
        .pc_inc      (if_pc_inc)
    );

endmodule
